// File: rtl/bcd_step_counter_if.sv
// Pin bundle of the two-digit BCD step counter: switch/key inputs toward the
// counter, BCD digits and debug pulses back toward the 7-segment decoders.
interface bcd_step_counter_if;
    logic       KEY_STEP;
    logic       SW_RUN;
    logic       SW_DOWN;
    logic [3:0] BCD_ONES;
    logic [3:0] BCD_TENS;
    logic       WRAP;
    logic       TICK;

    modport master (
        output KEY_STEP,
        output SW_RUN,
        output SW_DOWN,
        input  BCD_ONES,
        input  BCD_TENS,
        input  WRAP,
        input  TICK
    );

    modport slave (
        input  KEY_STEP,
        input  SW_RUN,
        input  SW_DOWN,
        output BCD_ONES,
        output BCD_TENS,
        output WRAP,
        output TICK
    );
endinterface

// File: rtl/bcd_step_counter.sv
// Two-digit BCD up/down counter (00..MAX_COUNT) stepped by a prescaled tick or
// a debounced key press; every input is synchronized, CLOCK_50 is the only clock.
module bcd_step_counter #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000,
    parameter int MAX_COUNT  = 29
) (
    input  logic               CLOCK_50,
    input  logic               RESET,
    bcd_step_counter_if.slave  io
);

    localparam int              PW         = $clog2(TICK_DIV);
    localparam int              DW         = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [DW-1:0]   DEB_LAST   = DW'(DEB_CYCLES - 1);
    localparam logic [DW-1:0]   DEB_ONE    = DW'(1);
    localparam logic [3:0]      MAX_TENS   = 4'(MAX_COUNT / 10);
    localparam logic [3:0]      MAX_ONES   = 4'(MAX_COUNT % 10);

    // Bit order in the synchronizer vectors: {key, run, down}
    logic [2:0]    meta_r;
    logic [2:0]    sync_r;
    logic          key_sync_s;
    logic          run_sync_s;
    logic          down_sync_s;

    logic [PW-1:0] presc_r;
    logic          tick_r;

    logic [DW-1:0] deb_cnt_r;
    logic          deb_key_r;
    logic          press_r;

    logic [3:0]    ones_r;
    logic [3:0]    tens_r;
    logic          wrap_r;
    logic [3:0]    ones_nxt_s;
    logic [3:0]    tens_nxt_s;
    logic          wrap_nxt_s;
    logic          step_s;

    assign key_sync_s  = sync_r[2];
    assign run_sync_s  = sync_r[1];
    assign down_sync_s = sync_r[0];
    assign step_s      = tick_r | press_r;

    // Two-flop synchronizers; reset to the idle (key released) level
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            meta_r <= 3'b111;
            sync_r <= 3'b111;
        end else begin
            meta_r <= {io.KEY_STEP, io.SW_RUN, io.SW_DOWN};
            sync_r <= meta_r;
        end
    end

    // Prescaler: held at zero while not running so a fresh enable waits a full period
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= 1'b0;
        end else if (!run_sync_s) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= 1'b0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= {PW{1'b0}};
            tick_r  <= 1'b1;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
            tick_r  <= 1'b0;
        end
    end

    // Debounce: accept a new key level only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            deb_cnt_r <= {DW{1'b0}};
            deb_key_r <= 1'b1;
            press_r   <= 1'b0;
        end else if (key_sync_s == deb_key_r) begin
            deb_cnt_r <= {DW{1'b0}};
            press_r   <= 1'b0;
        end else if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_r <= {DW{1'b0}};
            deb_key_r <= key_sync_s;
            press_r   <= ~key_sync_s;
        end else begin
            deb_cnt_r <= deb_cnt_r + DEB_ONE;
            press_r   <= 1'b0;
        end
    end

    // Next BCD value; tick and press landing together still make a single step
    always_comb begin
        ones_nxt_s = ones_r;
        tens_nxt_s = tens_r;
        wrap_nxt_s = 1'b0;
        if (step_s) begin
            if (down_sync_s) begin
                if ((ones_r == 4'd0) && (tens_r == 4'd0)) begin
                    ones_nxt_s = MAX_ONES;
                    tens_nxt_s = MAX_TENS;
                    wrap_nxt_s = 1'b1;
                end else if (ones_r == 4'd0) begin
                    ones_nxt_s = 4'd9;
                    tens_nxt_s = tens_r - 4'd1;
                end else begin
                    ones_nxt_s = ones_r - 4'd1;
                end
            end else begin
                if ((ones_r == MAX_ONES) && (tens_r == MAX_TENS)) begin
                    ones_nxt_s = 4'd0;
                    tens_nxt_s = 4'd0;
                    wrap_nxt_s = 1'b1;
                end else if (ones_r == 4'd9) begin
                    ones_nxt_s = 4'd0;
                    tens_nxt_s = tens_r + 4'd1;
                end else begin
                    ones_nxt_s = ones_r + 4'd1;
                end
            end
        end else begin
            wrap_nxt_s = 1'b0;
        end
    end

    // Registered digits and wrap pulse
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ones_r <= 4'd0;
            tens_r <= 4'd0;
            wrap_r <= 1'b0;
        end else begin
            ones_r <= ones_nxt_s;
            tens_r <= tens_nxt_s;
            wrap_r <= wrap_nxt_s;
        end
    end

    assign io.BCD_ONES = ones_r;
    assign io.BCD_TENS = tens_r;
    assign io.WRAP     = wrap_r;
    assign io.TICK     = tick_r;

endmodule
